// File: rtl/writeback_arbiter_if.sv
// writeback_arbiter_if: bundles the ALU, load-return and register-file write ports of the writeback arbiter.
//   master : drives ALU results and load returns, observes writeback, buffer state and mem_ready
//   slave  : the arbiter side
//   DEPTH  : load-return buffer entries; sizes fifo_count
interface writeback_arbiter_if #(parameter int DEPTH = 4);
    logic                     alu_valid;
    logic [4:0]               alu_rd;
    logic [31:0]              alu_data;
    logic                     mem_valid;
    logic                     mem_ready;
    logic [4:0]               mem_rd;
    logic [31:0]              mem_data;
    logic                     wb_we;
    logic [4:0]               wb_rd;
    logic [31:0]              wb_data;
    logic [31:0]              pending_mask;
    logic [$clog2(DEPTH):0]   fifo_count;

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        input  mem_ready, wb_we, wb_rd, wb_data, pending_mask, fifo_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        output mem_ready, wb_we, wb_rd, wb_data, pending_mask, fifo_count
    );
endinterface

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges never-stalled ALU results with buffered load returns into one register-file write port.
//   clk, reset   : clock, synchronous active-high reset
//   bus (slave)  : alu_* in, mem_* load returns with mem_ready backpressure,
//                  wb_* registered write port, pending_mask and fifo_count status
// ALU writes always win the port; the load buffer drains only in cycles without one.
// An ALU write kills older buffered loads to the same register so they pop silently.
module writeback_arbiter #(parameter int DEPTH = 4) (
    input logic clk,
    input logic reset,
    writeback_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]    rdQ   [DEPTH];
    logic [31:0]   dataQ [DEPTH];
    logic [DEPTH-1:0] live;
    logic [AW-1:0] rdPtr, wrPtr;
    logic [CW-1:0] count;
    logic          aluWrite, enq, pop, headLive;

    assign aluWrite       = bus.alu_valid && bus.alu_rd != 5'd0;
    assign bus.mem_ready  = count != CW'(DEPTH);
    assign enq            = bus.mem_valid && bus.mem_ready && bus.mem_rd != 5'd0;
    assign pop            = !aluWrite && count != '0;
    assign headLive       = live[rdPtr];
    assign bus.fifo_count = count;

    always_comb begin
        bus.pending_mask = '0;
        for (int i = 0; i < DEPTH; i++)
            if (live[i]) bus.pending_mask[rdQ[i]] = 1'b1;
        bus.pending_mask[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.wb_we   <= 1'b0;
            bus.wb_rd   <= '0;
            bus.wb_data <= '0;
            rdPtr       <= '0;
            wrPtr       <= '0;
            count       <= '0;
            live        <= '0;
        end else begin
            bus.wb_we <= aluWrite || (pop && headLive);
            if (aluWrite) begin
                bus.wb_rd   <= bus.alu_rd;
                bus.wb_data <= bus.alu_data;
            end else if (pop && headLive) begin
                bus.wb_rd   <= rdQ[rdPtr];
                bus.wb_data <= dataQ[rdPtr];
            end
            for (int i = 0; i < DEPTH; i++)
                if (aluWrite && rdQ[i] == bus.alu_rd) live[i] <= 1'b0;
            if (pop) begin
                live[rdPtr] <= 1'b0;
                rdPtr       <= rdPtr + 1'b1;
            end
            // Placed after the squash loop so a same-edge load to the ALU's rd stays live (it is younger).
            if (enq) begin
                live[wrPtr]  <= 1'b1;
                rdQ[wrPtr]   <= bus.mem_rd;
                dataQ[wrPtr] <= bus.mem_data;
                wrPtr        <= wrPtr + 1'b1;
            end
            count <= count + CW'(enq) - CW'(pop);
        end
    end
endmodule
